tdc_thermo_decoder: RTL and testbench

// - Consumer of the registered carry-chain TDC sample word: converts the thermometer code to
//   a binary edge position each clock and accumulates min/max/sum/hit statistics per window.
// - Sits directly after the TDC sampler in the same clk domain; results go to the readout logic.

---
 rtl/tdc_thermo_decoder_if.sv | 34 +++
 rtl/tdc_thermo_decoder.sv | 142 ++++++++++++++
 tb/tb_tdc_thermo_decoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_thermo_decoder_if.sv
// Bus bundle for tdc_thermo_decoder.
// Carries the TDC sample in, the per-sample edge position out, and the window-result handshake.
interface tdc_thermo_decoder_if #(
  parameter int TDC_WIDTH   = 32,
  parameter int WINDOW_LOG2 = 8
);
  localparam int POS_W = $clog2(TDC_WIDTH + 1);

  logic [TDC_WIDTH-1:0]         tdc_data;
  logic [POS_W-1:0]             pos;
  logic                         pos_polarity;
  logic                         pos_edge;
  logic                         pos_valid;
  logic                         start;
  logic                         busy;
  logic                         res_valid;
  logic                         res_ready;
  logic [POS_W-1:0]             res_min;
  logic [POS_W-1:0]             res_max;
  logic [POS_W+WINDOW_LOG2-1:0] res_sum;
  logic [WINDOW_LOG2:0]         res_hits;

  modport master (
    output tdc_data, start, res_ready,
    input  pos, pos_polarity, pos_edge, pos_valid, busy,
           res_valid, res_min, res_max, res_sum, res_hits
  );

  modport slave (
    input  tdc_data, start, res_ready,
    output pos, pos_polarity, pos_edge, pos_valid, busy,
           res_valid, res_min, res_max, res_sum, res_hits
  );
endinterface

// File: rtl/tdc_thermo_decoder.sv
// Thermometer-to-binary decoder for a carry-chain TDC, with per-window min/max/sum/hit statistics.
// Optional majority bubble filter in stage 2 is enabled by defining TDC_BUBBLE_FILTER_EN.
module tdc_thermo_decoder #(
  parameter int TDC_WIDTH   = 32,
  parameter int WINDOW_LOG2 = 8
) (
  input logic                 clk,
  input logic                 rst,
  tdc_thermo_decoder_if.slave bus
);
  localparam int POS_W = $clog2(TDC_WIDTH + 1);
  localparam int SUM_W = POS_W + WINDOW_LOG2;
  localparam logic [POS_W-1:0] POS_NONE = POS_W'(TDC_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [TDC_WIDTH-1:0]   d;
  logic [TDC_WIDTH-1:0]   f;
  logic [TDC_WIDTH-1:0]   f_next;
  logic [1:0]             vld_sr;
  logic [POS_W-1:0]       pos_next;
  logic                   edge_next;
  logic [WINDOW_LOG2-1:0] cnt;
  logic [POS_W-1:0]       acc_min;
  logic [POS_W-1:0]       acc_max;
  logic [SUM_W-1:0]       acc_sum;
  logic [WINDOW_LOG2:0]   acc_hits;
  logic [POS_W-1:0]       min_next;
  logic [POS_W-1:0]       max_next;
  logic [SUM_W-1:0]       sum_next;
  logic [WINDOW_LOG2:0]   hits_next;

  // End bits have only one neighbour, so they always pass through unfiltered.
  always_comb begin
    f_next = d;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int i = 1; i < TDC_WIDTH - 1; i++) begin
      f_next[i] = (d[i-1] & d[i]) | (d[i] & d[i+1]) | (d[i-1] & d[i+1]);
    end
`endif
  end

  always_comb begin
    pos_next  = POS_NONE;
    edge_next = 1'b0;
    for (int i = TDC_WIDTH - 1; i >= 1; i--) begin
      if (f[i] != f[0]) begin
        pos_next  = POS_W'(i);
        edge_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d                <= '0;
      f                <= '0;
      vld_sr           <= '0;
      bus.pos          <= '0;
      bus.pos_polarity <= 1'b0;
      bus.pos_edge     <= 1'b0;
      bus.pos_valid    <= 1'b0;
    end else begin
      d                <= bus.tdc_data;
      f                <= f_next;
      vld_sr           <= {vld_sr[0], 1'b1};
      bus.pos          <= pos_next;
      bus.pos_polarity <= f[0];
      bus.pos_edge     <= edge_next;
      bus.pos_valid    <= vld_sr[1];
    end
  end

  // Next accumulator values including the sample currently on pos.
  always_comb begin
    min_next  = acc_min;
    max_next  = acc_max;
    sum_next  = acc_sum;
    hits_next = acc_hits;
    if (bus.pos_edge) begin
      hits_next = acc_hits + (WINDOW_LOG2 + 1)'(1);
      sum_next  = acc_sum + SUM_W'(bus.pos);
      if (bus.pos < acc_min) min_next = bus.pos;
      if (bus.pos > acc_max) max_next = bus.pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      acc_min       <= '0;
      acc_max       <= '0;
      acc_sum       <= '0;
      acc_hits      <= '0;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_min   <= '0;
      bus.res_max   <= '0;
      bus.res_sum   <= '0;
      bus.res_hits  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.pos_valid) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            cnt      <= '0;
            acc_min  <= POS_NONE;
            acc_max  <= '0;
            acc_sum  <= '0;
            acc_hits <= '0;
          end
        end
        RUN: begin
          cnt      <= cnt + WINDOW_LOG2'(1);
          acc_min  <= min_next;
          acc_max  <= max_next;
          acc_sum  <= sum_next;
          acc_hits <= hits_next;
          if (cnt == '1) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.res_min   <= min_next;
            bus.res_max   <= max_next;
            bus.res_sum   <= sum_next;
            bus.res_hits  <= hits_next;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Testbench for tdc_thermo_decoder: random and directed TDC words checked against a
// run-length reference model, plus window statistics, result handshake and reset aborts.
module tb_tdc_thermo_decoder;
  localparam int W    = 32;
  localparam int WL   = 2;
  localparam int NS   = 1 << WL;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int rel_cyc = -100;

  int exp_pos   [HMAX];
  bit exp_pol   [HMAX];
  bit exp_edge  [HMAX];
  bit exp_known [HMAX];

  logic [W-1:0] win_words [$];

  tdc_thermo_decoder_if #(.TDC_WIDTH(W), .WINDOW_LOG2(WL)) bus ();

  tdc_thermo_decoder #(.TDC_WIDTH(W), .WINDOW_LOG2(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] ref_filter(input logic [W-1:0] d);
    logic [W-1:0] f;
    f = d;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int i = 1; i < W - 1; i++) begin
      f[i] = (int'(d[i-1]) + int'(d[i]) + int'(d[i+1])) >= 2;
    end
`endif
    return f;
  endfunction

  // The edge position is the length of the run of bit 0's value starting at the LSB.
  function automatic int ref_run(input logic [W-1:0] f);
    int n = 1;
    while (n < W && f[n] == f[0]) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    int p;
    int idx;
    p = $urandom_range(W, 0);
    w = (p == W) ? {W{1'b1}} : ((W'(1) << p) - W'(1));
    if ($urandom_range(1, 0) == 1) w = ~w;
    if ($urandom_range(3, 0) == 0) begin
      idx = $urandom_range(W - 1, 0);
      w[idx] = ~w[idx];
    end
    return w;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick_and_check();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_known[cyc]) begin
      check_output("pos", bus.pos, exp_pos[cyc]);
      check_output("pos_polarity", bus.pos_polarity, exp_pol[cyc]);
      check_output("pos_edge", bus.pos_edge, exp_edge[cyc]);
      check_output("pos_valid", bus.pos_valid, 1);
    end
    if (cyc - rel_cyc >= 1 && cyc - rel_cyc <= 3)
      check_output("pos_valid_after_reset", bus.pos_valid, (cyc - rel_cyc >= 3));
  endtask

  task automatic record(input int p, input bit pol, input bit e);
    if (!rst) begin
      exp_pos[cyc+3]   = p;
      exp_pol[cyc+3]   = pol;
      exp_edge[cyc+3]  = e;
      exp_known[cyc+3] = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic [W-1:0] word, input logic st);
    logic [W-1:0] f;
    int n;
    f = ref_filter(word);
    n = ref_run(f);
    bus.tdc_data = word;
    bus.start    = st;
    record(n, f[0], n < W);
    tick_and_check();
  endtask

  task automatic apply_directed(input logic [W-1:0] word, input int p, input bit pol, input bit e);
    bus.tdc_data = word;
    bus.start    = 1'b0;
    record(p, pol, e);
    tick_and_check();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_pos"}, bus.pos, 0);
    check_output({tag, "_pos_polarity"}, bus.pos_polarity, 0);
    check_output({tag, "_pos_edge"}, bus.pos_edge, 0);
    check_output({tag, "_pos_valid"}, bus.pos_valid, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_res_valid"}, bus.res_valid, 0);
    check_output({tag, "_res_min"}, bus.res_min, 0);
    check_output({tag, "_res_max"}, bus.res_max, 0);
    check_output({tag, "_res_sum"}, bus.res_sum, 0);
    check_output({tag, "_res_hits"}, bus.res_hits, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    for (int i = cyc + 1; i <= cyc + 4; i++) exp_known[i] = 1'b0;
    tick_and_check();
    tick_and_check();
    rst     = 1'b0;
    rel_cyc = cyc;
  endtask

  // Words k is driven so that its position reaches pos during the k-th RUN cycle.
  task automatic run_window(input int hold_cycles);
    int s;
    int e_min;
    int e_max;
    int e_sum;
    int e_hits;
    int budget;
    apply_stimulus(win_words[0], 1'b0);
    apply_stimulus(win_words[1], 1'b0);
    s = cyc;
    check_output("pos_valid_at_start", bus.pos_valid, 1);
    apply_stimulus(win_words[2], 1'b1);
    check_output("busy_in_run", bus.busy, 1);
    for (int k = 3; k < NS; k++) apply_stimulus(win_words[k], 1'b0);
    e_min = W; e_max = 0; e_sum = 0; e_hits = 0;
    for (int k = 1; k <= NS; k++) begin
      if (exp_edge[s+k]) begin
        e_hits++;
        e_sum += exp_pos[s+k];
        if (exp_pos[s+k] < e_min) e_min = exp_pos[s+k];
        if (exp_pos[s+k] > e_max) e_max = exp_pos[s+k];
      end
    end
    budget = 0;
    while (!bus.res_valid && budget < 20) begin
      apply_stimulus(rand_word(), 1'b0);
      budget++;
    end
    check_output("res_latency", cyc - s, NS + 1);
    check_output("res_min", bus.res_min, e_min);
    check_output("res_max", bus.res_max, e_max);
    check_output("res_sum", bus.res_sum, e_sum);
    check_output("res_hits", bus.res_hits, e_hits);
    check_output("busy_in_done", bus.busy, 0);
    for (int h = 0; h < hold_cycles; h++) begin
      apply_stimulus(rand_word(), h == 2);
      check_output("hold_res_valid", bus.res_valid, 1);
      check_output("hold_busy", bus.busy, 0);
      check_output("hold_res_min", bus.res_min, e_min);
      check_output("hold_res_max", bus.res_max, e_max);
      check_output("hold_res_sum", bus.res_sum, e_sum);
      check_output("hold_res_hits", bus.res_hits, e_hits);
    end
    bus.res_ready = 1'b1;
    apply_stimulus(rand_word(), 1'b0);
    bus.res_ready = 1'b0;
    check_output("idle_res_valid", bus.res_valid, 0);
    apply_stimulus(rand_word(), 1'b0);
    check_output("idle_busy", bus.busy, 0);
    check_output("idle_res_valid_2", bus.res_valid, 0);
    check_output("idle_res_min", bus.res_min, e_min);
    check_output("idle_res_max", bus.res_max, e_max);
    check_output("idle_res_sum", bus.res_sum, e_sum);
    check_output("idle_res_hits", bus.res_hits, e_hits);
  endtask

  initial begin
    bus.tdc_data  = '0;
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    check_all_zero("reset_initial");
    tick_and_check();
    tick_and_check();
    rst     = 1'b0;
    rel_cyc = cyc;

    // Start while pos_valid is still low must be ignored.
    apply_stimulus(rand_word(), 1'b1);
    check_output("start_ignored_not_valid", bus.busy, 0);

    apply_directed(32'h000000FF, 8, 1'b1, 1'b1);
    apply_directed(32'hFFFFFF00, 8, 1'b0, 1'b1);
`ifdef TDC_BUBBLE_FILTER_EN
    apply_directed(32'h000000F7, 8, 1'b1, 1'b1);
`else
    apply_directed(32'h000000F7, 3, 1'b1, 1'b1);
`endif
    apply_directed(32'hFFFFFFFF, 32, 1'b1, 1'b0);
    apply_directed(32'h00000000, 32, 1'b0, 1'b0);
    apply_directed(32'h7FFFFFFF, 31, 1'b1, 1'b1);
    apply_directed(32'hFFFFFFFE, 1, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) apply_stimulus(rand_word(), 1'b0);

    win_words = '{32'h000000FF, 32'h000003FF, 32'h00000FFF, 32'h00003FFF};
    run_window(10);

    win_words = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_window(0);

    for (int r = 0; r < 6; r++) begin
      win_words = '{rand_word(), rand_word(), rand_word(), rand_word()};
      run_window($urandom_range(3, 0));
    end

    for (int i = 0; i < 3; i++) apply_stimulus(rand_word(), 1'b0);
    apply_reset("reset_midstream");
    for (int i = 0; i < 5; i++) apply_stimulus(rand_word(), 1'b0);

    apply_stimulus(rand_word(), 1'b1);
    check_output("busy_before_abort", bus.busy, 1);
    apply_stimulus(rand_word(), 1'b0);
    apply_reset("reset_mid_run");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(rand_word(), 1'b0);
      check_output("abort_res_valid", bus.res_valid, 0);
      check_output("abort_busy", bus.busy, 0);
    end

    win_words = '{rand_word(), rand_word(), rand_word(), rand_word()};
    run_window(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
